// File: rtl/pipeline_types.sv
// Shared pipeline control types: the pause vector / flush bundle and the
// decoded per-stage action used by stage registers.
package pipeline_types;

    localparam int PAUSE_W = 8;

    typedef struct packed {
        logic [PAUSE_W-1:0] pause;
        logic               exception_flush;
    } ctrl_t;

    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_ADVANCE = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_e;

    // Flush beats bubble beats advance beats hold. A stage bubbles when it is
    // paused but its consumer is not, so the consumer sees an empty slot.
    function automatic stage_act_e decode_act(input ctrl_t c, input int unsigned stage);
        stage_act_e act;
        act = ACT_HOLD;
        if (c.exception_flush) begin
            act = ACT_FLUSH;
        end else if (c.pause[stage] && !c.pause[stage + 1]) begin
            act = ACT_BUBBLE;
        end else if (!c.pause[stage]) begin
            act = ACT_ADVANCE;
        end
        return act;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics; clr is synchronous and
// dominates inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-lane pipeline stage register with pause/bubble/flush handling,
// per-lane kill, and saturating stall/bubble counters.
module pipe_stage_reg
    import pipeline_types::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = 64,
    parameter int STAGE  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  ctrl_t                         ctrl,
    input  logic [LANES-1:0]              kill_i,
    input  logic [LANES-1:0]              in_valid,
    input  logic [LANES-1:0][DATA_W-1:0]  in_data,
    output logic [LANES-1:0]              out_valid,
    output logic [LANES-1:0][DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              bubble_cnt
);

    stage_act_e act;
    logic       do_hold;
    logic       do_bubble;
    logic       unused_pause;

    assign act       = decode_act(ctrl, STAGE);
    assign do_hold   = (act == ACT_HOLD);
    assign do_bubble = (act == ACT_BUBBLE);

    // Only two pause bits matter to this stage; the rest belong to neighbours.
    assign unused_pause = ^ctrl.pause;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic              valid_reg;
            logic              valid_next;
            logic [DATA_W-1:0] data_reg;
            logic [DATA_W-1:0] data_next;

            // Payload is forced to zero whenever the lane is not valid, so
            // downstream never sees a stale value.
            always_comb begin
                valid_next = valid_reg;
                data_next  = data_reg;
                case (act)
                    ACT_FLUSH, ACT_BUBBLE: begin
                        valid_next = 1'b0;
                        data_next  = '0;
                    end
                    ACT_ADVANCE: begin
                        valid_next = in_valid[gi] & ~kill_i[gi];
                        data_next  = valid_next ? in_data[gi] : '0;
                    end
                    default: begin
                        if (kill_i[gi]) begin
                            valid_next = 1'b0;
                            data_next  = '0;
                        end
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    valid_reg <= valid_next;
                    data_reg  <= data_next;
                end
            end

            assign out_valid[gi] = valid_reg;
            assign out_data[gi]  = data_reg;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (do_hold),
        .count (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (do_bubble),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Table-driven bench for pipe_stage_reg: each vector is queued with its
// expected outputs and compared one clock later.
module tb_pipe_stage_reg;
    import pipeline_types::*;

    localparam int LANES  = 2;
    localparam int DATA_W = 64;
    localparam int STAGE  = 4;
    localparam int CNT_W  = 4;

    localparam logic [63:0] DA = 64'hA5A5_0000_1111_0001;
    localparam logic [63:0] DB = 64'hB6B6_0000_2222_0002;
    localparam logic [63:0] DC = 64'hC7C7_0000_3333_0003;
    localparam logic [63:0] DD = 64'hD8D8_0000_4444_0004;

    logic                          clk = 1'b0;
    logic                          rst;
    ctrl_t                         ctrl;
    logic [LANES-1:0]              kill_i;
    logic [LANES-1:0]              in_valid;
    logic [LANES-1:0][DATA_W-1:0]  in_data;
    logic [LANES-1:0]              out_valid;
    logic [LANES-1:0][DATA_W-1:0]  out_data;
    logic [CNT_W-1:0]              stall_cnt;
    logic [CNT_W-1:0]              bubble_cnt;

    pipe_stage_reg #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .STAGE  (STAGE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl       (ctrl),
        .kill_i     (kill_i),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        cur;
        logic        nxt;
        logic [1:0]  kill;
        logic [1:0]  vin;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [1:0]  ev;
        logic [63:0] e0;
        logic [63:0] e1;
        logic [3:0]  es;
        logic [3:0]  eb;
    } vec_t;

    vec_t vecs[17];
    vec_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   txn    = 0;

    function automatic vec_t mk(input logic r, input logic f, input logic c, input logic n,
                                input logic [1:0] k, input logic [1:0] vi,
                                input logic [63:0] d0, input logic [63:0] d1,
                                input logic [1:0] ev, input logic [63:0] e0, input logic [63:0] e1,
                                input logic [3:0] es, input logic [3:0] eb);
        vec_t v;
        v.rst = r; v.flush = f; v.cur = c; v.nxt = n; v.kill = k; v.vin = vi;
        v.d0 = d0; v.d1 = d1; v.ev = ev; v.e0 = e0; v.e1 = e1; v.es = es; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v === exp_v) begin
            passed++;
        end else begin
            $display("FAIL %s txn %0d: got %h want %h", nm, txn, act_v, exp_v);
        end
    endtask

    task automatic compare_front();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_empty txn %0d: got 0 entries want 1", txn);
            return;
        end
        e = exp_q.pop_front();
        chk("out_valid",  64'(out_valid),  64'(e.ev));
        chk("out_data0",  out_data[0],     e.e0);
        chk("out_data1",  out_data[1],     e.e1);
        chk("stall_cnt",  64'(stall_cnt),  64'(e.es));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(e.eb));
        $display("txn %0d: rst=%0b fl=%0b p=%0b%0b kill=%b vin=%b -> valid=%b d0=%h d1=%h stall=%0d bubble=%0d",
                 txn, e.rst, e.flush, e.nxt, e.cur, e.kill, e.vin,
                 out_valid, out_data[0], out_data[1], stall_cnt, bubble_cnt);
        txn++;
    endtask

    // Drive on the falling edge, let one rising edge capture, check on the next falling edge.
    task automatic apply(input vec_t v);
        logic [PAUSE_W-1:0] p;
        p = PAUSE_W'($urandom);
        p[STAGE]     = v.cur;
        p[STAGE + 1] = v.nxt;
        ctrl.pause           = p;
        ctrl.exception_flush = v.flush;
        rst       = v.rst;
        kill_i    = v.kill;
        in_valid  = v.vin;
        in_data[0] = v.d0;
        in_data[1] = v.d1;
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        compare_front();
    endtask

    initial begin
        rst = 1'b1;
        ctrl = '0;
        kill_i = '0;
        in_valid = '0;
        in_data = '0;

        //            rst  fl   cur  nxt  kill   vin    d0  d1   ev     e0  e1  st    bu
        vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,2'b00,2'b11, DA, DB, 2'b00, 0,  0,  4'd0, 4'd0);
        vecs[1]  = mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b11, DA, DB, 2'b11, DA, DB, 4'd0, 4'd0);
        vecs[2]  = mk(1'b0,1'b0,1'b1,1'b1,2'b10,2'b11, DC, DD, 2'b01, DA, 0,  4'd1, 4'd0);
        vecs[3]  = mk(1'b0,1'b0,1'b1,1'b1,2'b00,2'b11, DC, DD, 2'b01, DA, 0,  4'd2, 4'd0);
        vecs[4]  = mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01, DC, DD, 2'b01, DC, 0,  4'd2, 4'd0);
        vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,2'b11,2'b11, DC, DD, 2'b00, 0,  0,  4'd2, 4'd0);
        vecs[6]  = mk(1'b0,1'b0,1'b0,1'b0,2'b01,2'b11, DA, DB, 2'b10, 0,  DB, 4'd2, 4'd0);
        vecs[7]  = mk(1'b0,1'b0,1'b1,1'b0,2'b00,2'b11, DA, DB, 2'b00, 0,  0,  4'd2, 4'd1);
        vecs[8]  = mk(1'b0,1'b0,1'b1,1'b0,2'b11,2'b11, DA, DB, 2'b00, 0,  0,  4'd2, 4'd2);
        vecs[9]  = mk(1'b0,1'b0,1'b1,1'b0,2'b00,2'b11, DA, DB, 2'b00, 0,  0,  4'd2, 4'd3);
        vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b11, DA, DB, 2'b11, DA, DB, 4'd2, 4'd3);
        vecs[11] = mk(1'b0,1'b1,1'b1,1'b0,2'b11,2'b11, DC, DD, 2'b00, 0,  0,  4'd2, 4'd3);
        vecs[12] = mk(1'b0,1'b1,1'b0,1'b0,2'b00,2'b11, DC, DD, 2'b00, 0,  0,  4'd2, 4'd3);
        vecs[13] = mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b11, DA, DB, 2'b11, DA, DB, 4'd2, 4'd3);
        vecs[14] = mk(1'b0,1'b0,1'b1,1'b1,2'b00,2'b11, DC, DD, 2'b11, DA, DB, 4'd3, 4'd3);
        vecs[15] = mk(1'b1,1'b1,1'b1,1'b1,2'b11,2'b11, DC, DD, 2'b00, 0,  0,  4'd0, 4'd0);
        vecs[16] = mk(1'b0,1'b0,1'b1,1'b1,2'b00,2'b11, DC, DD, 2'b00, 0,  0,  4'd1, 4'd0);

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            apply(vecs[i]);
        end

        // Saturation: reset, load A/B, then hold long enough to pin stall_cnt at 15.
        apply(mk(1'b1,1'b0,1'b0,1'b0,2'b00,2'b00, 0,  0,  2'b00, 0,  0,  4'd0, 4'd0));
        apply(mk(1'b0,1'b0,1'b0,1'b0,2'b00,2'b11, DA, DB, 2'b11, DA, DB, 4'd0, 4'd0));
        for (int i = 1; i <= 20; i++) begin
            logic [3:0] es;
            es = (i > 15) ? 4'd15 : 4'(i);
            apply(mk(1'b0,1'b0,1'b1,1'b1,2'b00,2'b11, DC, DD, 2'b11, DA, DB, es, 4'd0));
        end
        // Bubble after saturated stall: contents cleared, stall stays pinned.
        apply(mk(1'b0,1'b0,1'b1,1'b0,2'b00,2'b11, DC, DD, 2'b00, 0,  0,  4'd15, 4'd1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning the number of parallel issue lanes carried by the stage.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the per-lane payload width in bits.
REQ-003 SHALL have parameter STAGE, default 4, meaning the index into ctrl.pause owned by this register; legal range 0..PAUSE_W-2.
REQ-004 SHALL have parameter CNT_W, default 32, meaning the width of the performance counters.
REQ-005 SHALL have port clk, input, 1 bit, the clock.
REQ-006 SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-007 SHALL have port ctrl, input, ctrl_t, carrying the pipeline pause vector and exception_flush.
REQ-008 SHALL have port kill_i, input, LANES bits, a per-lane squash mask (branch mispredict, younger-lane kill).
REQ-009 SHALL have port in_valid, input, LANES bits, the upstream lane valids.
REQ-010 SHALL have port in_data, input, LANES x DATA_W, the upstream lane payloads.
REQ-011 SHALL have port out_valid, output, LANES bits, the registered lane valids.
REQ-012 SHALL have port out_data, output, LANES x DATA_W, the registered lane payloads.
REQ-013 SHALL have port stall_cnt, output, CNT_W bits, the count of hold cycles.
REQ-014 SHALL have port bubble_cnt, output, CNT_W bits, the count of bubble-insert cycles.

Function
REQ-015 Stage SHALL be a single register with 1-cycle latency from in_* to out_*, and no combinational path from input to output.
REQ-016 Next-state actions, in strict priority order: rst > ctrl.exception_flush > bubble > advance > hold.
REQ-017 Flush: all out_valid and out_data SHALL be zero next cycle; counters SHALL NOT change.
REQ-018 Bubble (pause[STAGE]=1 and pause[STAGE+1]=0): all lanes SHALL be zeroed; bubble_cnt SHALL increment.
REQ-019 Advance (pause[STAGE]=0): lane k SHALL load in_valid[k] & ~kill_i[k], and in_data[k] when that result is 1, else zero.
REQ-020 Hold (pause[STAGE]=1 and pause[STAGE+1]=1): contents SHALL be retained, except lanes with kill_i[k]=1, which SHALL become valid 0 / data 0; stall_cnt SHALL increment.
REQ-021 kill_i SHALL be ignored on flush and bubble cycles, since those already clear every lane.
REQ-022 Any lane with out_valid=0 SHALL present out_data=0, with no stale payload.
REQ-023 Counters SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-024 Lanes SHALL be independent; the all-lanes-killed case during advance SHALL yield an all-zero register with no counter increment.

Reset
REQ-025 On rst=1 at a clk edge: out_valid, out_data, stall_cnt and bubble_cnt SHALL all be 0.
REQ-026 rst SHALL override every simultaneous flush, pause or kill condition.
REQ-027 Reset asserted mid-hold SHALL discard the held contents.

Structure
REQ-028 ctrl_t and PAUSE_W SHALL come from pipeline_types; the module SHALL NOT add any typedef.
REQ-029 One sub-module, sat_counter (parameter W; inputs inc and clr), SHALL be instantiated twice for the performance counters.
REQ-030 Lane logic SHALL be a generate loop over LANES, with no lane-specific code.

Verification
REQ-031 Advance: with pause=0, drive in_valid=2'b11, data A/B, kill=0 -> next cycle out_valid=11, out_data=A/B.
REQ-032 Hold with kill: with pause[4]=1, pause[5]=1, kill=2'b10 -> lane0 holds A, lane1 becomes valid 0 / data 0, and stall_cnt goes 0->1.
REQ-033 Bubble: with pause[4]=1 and pause[5]=0 for 3 cycles -> outputs are zero and bubble_cnt=3.
REQ-034 Priority: assert exception_flush together with the bubble condition and kill=11 -> outputs are zero and both counters are unchanged.
REQ-035 Saturation: with CNT_W=4, hold for 20 cycles -> stall_cnt=15, and it stays at 15.
REQ-036 Reset mid-hold: hold valid data, then assert rst for 1 cycle -> all outputs are 0 and counters are 0 the next cycle.
